// File: rtl/ipr_bulk_writer.sv
// ipr_bulk_writer
//   Initiator-side engine for an IPR write port. Pulls words from a local
//   valid/ready stream and issues one single-word IPR write per word, with at
//   most one transaction outstanding. After BULK_NUMBER acknowledged words it
//   pulses bulk_done. A per-phase watchdog aborts the bulk if the slave stalls
//   in the request or response phase.
//
// Ports
//   clk, rst_n           block clock, synchronous active-low reset
//   start                one-cycle pulse, begins a bulk when idle
//   s_valid/s_data/s_ready   local stream (word taken on s_valid & s_ready)
//   ipr_req/ipr_we       IPR write request (ipr_we mirrors ipr_req)
//   ipr_addr             constant BASE_ADDR (DATA register)
//   ipr_wdata            held stream word, zero-extended to 32 bits
//   ipr_gnt              slave grant, may be combinational in the req cycle
//   ipr_rvalid           slave write response
//   busy                 high whenever the engine is not idle
//   bulk_done            one-cycle pulse after the last word is acknowledged
//   timeout_err          sticky watchdog abort flag, cleared by an accepted start
//   words_sent           words acknowledged in the current or last bulk
//
// Every output is either a register or a decode of the state register, so no
// input reaches an output combinationally.
module ipr_bulk_writer #(
    parameter int unsigned DSIZE          = 32,
    parameter int unsigned BULK_NUMBER    = 10,
    parameter int unsigned WATCHDOG_LIMIT = 100,
    parameter logic [31:0] BASE_ADDR      = 32'h0000_0000
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic             s_valid,
    input  logic [DSIZE-1:0] s_data,
    output logic             s_ready,
    output logic             ipr_req,
    output logic             ipr_we,
    output logic [31:0]      ipr_addr,
    output logic [31:0]      ipr_wdata,
    input  logic             ipr_gnt,
    input  logic             ipr_rvalid,
    output logic             busy,
    output logic             bulk_done,
    output logic             timeout_err,
    output logic [15:0]      words_sent
);

    typedef enum logic [2:0] {
        IDLE = 3'd0,
        LOAD = 3'd1,
        REQ  = 3'd2,
        RESP = 3'd3,
        DONE = 3'd4
    } state_t;

    // Counter wide enough to hold WATCHDOG_LIMIT itself.
    localparam int WD_W = (WATCHDOG_LIMIT < 2) ? 1 : $clog2(WATCHDOG_LIMIT + 1);
    // The counter reads 0 in the first cycle of a phase, so the N-th cycle of
    // the phase is the one where it reads N-1.
    localparam logic [WD_W-1:0] WD_LAST = WD_W'(WATCHDOG_LIMIT - 1);

    state_t          state;
    state_t          next_state;
    logic [WD_W-1:0] wd_cnt;
    logic [31:0]     hold;
    logic [15:0]     words_inc;

    logic start_acc;
    logic capture;
    logic ack;
    logic wd_expired;
    logic abort;
    logic last_word;

    // ------------------------------------------------------------------
    // Event decode
    // ------------------------------------------------------------------
    assign start_acc  = (state == IDLE) && start;
    assign capture    = (state == LOAD) && s_valid;
    assign ack        = (state == RESP) && ipr_rvalid;
    assign wd_expired = (wd_cnt == WD_LAST);

    // A grant or response arriving in the limit cycle takes priority over
    // the abort, so the abort terms are qualified with their absence.
    assign abort = wd_expired &&
                   (((state == REQ)  && !ipr_gnt) ||
                    ((state == RESP) && !ipr_rvalid));

    // Saturating increment; BULK_NUMBER is compared at full width so a
    // parameter above 16 bits simply never terminates on count.
    assign words_inc = (words_sent == 16'hFFFF) ? 16'hFFFF : (words_sent + 16'd1);
    assign last_word = (32'(words_inc) == BULK_NUMBER);

    // ------------------------------------------------------------------
    // FSM state register
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= next_state;
        end
    end

    // ------------------------------------------------------------------
    // FSM next-state logic
    // ------------------------------------------------------------------
    always_comb begin
        next_state = state;
        case (state)
            IDLE: begin
                if (start) begin
                    next_state = LOAD;
                end
            end
            LOAD: begin
                if (s_valid) begin
                    next_state = REQ;
                end
            end
            REQ: begin
                if (ipr_gnt) begin
                    next_state = RESP;
                end else if (abort) begin
                    next_state = IDLE;
                end
            end
            RESP: begin
                if (ipr_rvalid) begin
                    next_state = last_word ? DONE : LOAD;
                end else if (abort) begin
                    next_state = IDLE;
                end
            end
            DONE: begin
                next_state = IDLE;
            end
            default: begin
                next_state = IDLE;
            end
        endcase
    end

    // ------------------------------------------------------------------
    // Watchdog: cleared on every state change so each REQ and RESP phase
    // starts from zero, counting only while waiting on the slave.
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            wd_cnt <= '0;
        end else if (next_state != state) begin
            wd_cnt <= '0;
        end else if (((state == REQ) || (state == RESP)) && !wd_expired) begin
            wd_cnt <= wd_cnt + 1'b1;
        end
    end

    // ------------------------------------------------------------------
    // Hold register: captured once per word in LOAD and left untouched
    // through REQ/RESP so address/data stay stable until the grant.
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            hold <= '0;
        end else if (capture) begin
            hold <= 32'(s_data);
        end
    end

    // ------------------------------------------------------------------
    // Bulk bookkeeping
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            words_sent <= '0;
        end else if (start_acc) begin
            words_sent <= '0;
        end else if (ack) begin
            words_sent <= words_inc;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            timeout_err <= 1'b0;
        end else if (start_acc) begin
            timeout_err <= 1'b0;
        end else if (abort) begin
            timeout_err <= 1'b1;
        end
    end

    // ------------------------------------------------------------------
    // State-decoded outputs
    // ------------------------------------------------------------------
    assign s_ready   = (state == LOAD);
    assign ipr_req   = (state == REQ);
    assign ipr_we    = (state == REQ);
    assign busy      = (state != IDLE);
    assign bulk_done = (state == DONE);
    assign ipr_addr  = BASE_ADDR;
    assign ipr_wdata = hold;

endmodule

// File: tb/tb_ipr_bulk_writer.sv
module tb_ipr_bulk_writer;

    localparam logic [31:0] BASE = 32'h1000_0000;

    logic        clk;
    logic        rst_n;
    logic        start;
    logic        s_valid;
    logic [15:0] s_data;
    logic        ipr_gnt;
    logic        ipr_rvalid;

    // dut_a: roomy watchdog for functional runs; dut_b: WATCHDOG_LIMIT=5.
    logic        a_s_ready, a_req, a_we, a_busy, a_done, a_tmo;
    logic [31:0] a_addr, a_wdata;
    logic [15:0] a_words;
    logic        b_s_ready, b_req, b_we, b_busy, b_done, b_tmo;
    logic [31:0] b_addr, b_wdata;
    logic [15:0] b_words;

    ipr_bulk_writer #(.DSIZE(16), .BULK_NUMBER(4), .WATCHDOG_LIMIT(16), .BASE_ADDR(BASE)) dut_a (
        .clk(clk), .rst_n(rst_n), .start(start), .s_valid(s_valid), .s_data(s_data),
        .s_ready(a_s_ready), .ipr_req(a_req), .ipr_we(a_we), .ipr_addr(a_addr),
        .ipr_wdata(a_wdata), .ipr_gnt(ipr_gnt), .ipr_rvalid(ipr_rvalid), .busy(a_busy),
        .bulk_done(a_done), .timeout_err(a_tmo), .words_sent(a_words)
    );

    ipr_bulk_writer #(.DSIZE(16), .BULK_NUMBER(4), .WATCHDOG_LIMIT(5), .BASE_ADDR(BASE)) dut_b (
        .clk(clk), .rst_n(rst_n), .start(start), .s_valid(s_valid), .s_data(s_data),
        .s_ready(b_s_ready), .ipr_req(b_req), .ipr_we(b_we), .ipr_addr(b_addr),
        .ipr_wdata(b_wdata), .ipr_gnt(ipr_gnt), .ipr_rvalid(ipr_rvalid), .busy(b_busy),
        .bulk_done(b_done), .timeout_err(b_tmo), .words_sent(b_words)
    );

    logic        sel;
    logic        m_s_ready, m_req, m_we, m_busy, m_done, m_tmo;
    logic [31:0] m_addr, m_wdata;
    logic [15:0] m_words;

    assign m_s_ready = sel ? b_s_ready : a_s_ready;
    assign m_req     = sel ? b_req     : a_req;
    assign m_we      = sel ? b_we      : a_we;
    assign m_busy    = sel ? b_busy    : a_busy;
    assign m_done    = sel ? b_done    : a_done;
    assign m_tmo     = sel ? b_tmo     : a_tmo;
    assign m_addr    = sel ? b_addr    : a_addr;
    assign m_wdata   = sel ? b_wdata   : a_wdata;
    assign m_words   = sel ? b_words   : a_words;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int checks;
    int errors;
    int cyc;
    int req_cycles, stall_cycles, wr_cnt, done_cnt;
    logic [31:0] exp_q[$];

    // slave model configuration
    int gnt_wait, rv_delay, block_gnt;
    bit stray_rv, chk_hold;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Slave: grants after gnt_wait stalled REQ cycles, responds rv_delay
    // cycles after the cycle following the grant; refuses grant #block_gnt.
    task automatic slave();
        int wait_cnt = 0;
        int rv_cnt = -1;
        int gnt_cnt = 0;
        forever begin
            @(negedge clk);
            ipr_gnt = 1'b0;
            ipr_rvalid = 1'b0;
            if (!rst_n) begin
                wait_cnt = 0; rv_cnt = -1; gnt_cnt = 0;
            end else if (stray_rv) begin
                ipr_rvalid = 1'b1;
                stray_rv = 1'b0;
            end else if (rv_cnt >= 0) begin
                if (rv_cnt == 0) ipr_rvalid = 1'b1;
                rv_cnt--;
            end else if (m_req) begin
                if (gnt_cnt != block_gnt && wait_cnt >= gnt_wait) begin
                    ipr_gnt = 1'b1;
                    wait_cnt = 0;
                    gnt_cnt++;
                    rv_cnt = rv_delay;
                end else begin
                    wait_cnt++;
                end
            end else begin
                wait_cnt = 0;
            end
        end
    endtask

    // Monitor: pops the scoreboard on every granted write.
    task automatic monitor();
        bit          prev_stall = 1'b0;
        logic [31:0] prev_wdata = '0;
        forever begin
            @(negedge clk);
            #1;
            if (rst_n) begin
                if (m_req) req_cycles++;
                if (m_req && !ipr_gnt) stall_cycles++;
                if (chk_hold && prev_stall) begin
                    chk("hold_req", m_req, 1);
                    chk("hold_wdata", m_wdata, prev_wdata);
                end
                if (m_req && ipr_gnt) begin
                    wr_cnt++;
                    chk("sb_pending", exp_q.size() != 0, 1);
                    if (exp_q.size() != 0) chk("wdata", m_wdata, exp_q.pop_front());
                    chk("we", m_we, 1);
                    chk("addr", m_addr, BASE);
                end
                if (m_done) done_cnt++;
                prev_stall = m_req && !ipr_gnt;
                prev_wdata = m_wdata;
            end else begin
                prev_stall = 1'b0;
            end
        end
    endtask

    task automatic clr_stats();
        req_cycles = 0; stall_cycles = 0; wr_cnt = 0; done_cnt = 0;
    endtask

    task automatic do_reset();
        rst_n = 1'b0; start = 1'b0; s_valid = 1'b0;
        gnt_wait = 0; rv_delay = 0; block_gnt = -1; stray_rv = 1'b0; chk_hold = 1'b0;
        repeat (2) @(negedge clk);
        exp_q.delete();
        rst_n = 1'b1;
        clr_stats();
    endtask

    task automatic pulse_start();
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
    endtask

    // Offer one word; pushes the expectation once the handshake is certain.
    task automatic feed(input logic [15:0] w, input int gap, output bit ok);
        ok = 1'b0;
        s_valid = 1'b0;
        repeat (gap) @(negedge clk);
        s_valid = 1'b1;
        s_data = w;
        for (int i = 0; i < 100; i++) begin
            if (m_s_ready) begin
                ok = 1'b1;
                exp_q.push_back({16'h0, w});
                @(negedge clk);
                break;
            end
            @(negedge clk);
        end
        s_valid = 1'b0;
    endtask

    task automatic run_bulk(input logic [15:0] base, input int gap, input int n);
        bit ok;
        for (int i = 0; i < n; i++) begin
            feed(base + 16'(i), (i == 0) ? 0 : gap, ok);
            chk("feed_accept", ok, 1);
        end
    endtask

    // which: 0 = bulk_done, 1 = idle, 2 = s_ready
    task automatic wait_for(input int which, input int limit, output bit seen);
        seen = 1'b0;
        for (int i = 0; i < limit; i++) begin
            if ((which == 0 && m_done) || (which == 1 && !m_busy) || (which == 2 && m_s_ready)) begin
                seen = 1'b1;
                break;
            end
            @(negedge clk);
        end
    endtask

    initial begin
        bit seen;
        bit ok;
        int t0;
        checks = 0; errors = 0; cyc = 0;
        sel = 1'b0; s_data = '0; ipr_gnt = 1'b0; ipr_rvalid = 1'b0;
        rst_n = 1'b0; start = 1'b0; s_valid = 1'b0;
        gnt_wait = 0; rv_delay = 0; block_gnt = -1; stray_rv = 1'b0; chk_hold = 1'b0;
        clr_stats();
        fork
            slave();
            monitor();
            forever @(posedge clk) cyc++;
            begin
                #400000;
                $display("FAIL global_timeout checks=%0d", checks);
                $fatal(1, "bench time limit");
            end
        join_none

        // ---- reset values
        repeat (3) @(negedge clk);
        chk("rst_s_ready", m_s_ready, 0);
        chk("rst_req", m_req, 0);
        chk("rst_we", m_we, 0);
        chk("rst_addr", m_addr, BASE);
        chk("rst_wdata", m_wdata, 0);
        chk("rst_busy", m_busy, 0);
        chk("rst_done", m_done, 0);
        chk("rst_tmo", m_tmo, 0);
        chk("rst_words", m_words, 0);
        rst_n = 1'b1;
        @(negedge clk);

        // ---- nominal bulk
        do_reset();
        pulse_start();
        t0 = cyc;
        chk("start_busy", m_busy, 1);
        chk("start_s_ready", m_s_ready, 1);
        run_bulk(16'h00A0, 0, 4);
        wait_for(0, 50, seen);
        chk("nom_done_seen", seen, 1);
        chk("nom_latency", cyc - t0, 12);
        @(negedge clk);
        chk("nom_busy_after", m_busy, 0);
        repeat (2) @(negedge clk);
        chk("nom_words", m_words, 4);
        chk("nom_done_cnt", done_cnt, 1);
        chk("nom_writes", wr_cnt, 4);
        chk("nom_sb_empty", exp_q.size(), 0);

        // ---- backpressure: 7 stalled REQ cycles per word
        do_reset();
        gnt_wait = 7;
        chk_hold = 1'b1;
        pulse_start();
        run_bulk(16'h0150, 0, 4);
        wait_for(0, 100, seen);
        chk("bp_done_seen", seen, 1);
        repeat (3) @(negedge clk);
        chk("bp_stalls", stall_cycles, 28);
        chk("bp_words", m_words, 4);
        chk("bp_writes", wr_cnt, 4);
        chk("bp_sb_empty", exp_q.size(), 0);
        chk("bp_tmo", m_tmo, 0);

        // ---- stream bubbles: 3 idle cycles between words
        do_reset();
        pulse_start();
        run_bulk(16'h0C30, 3, 4);
        wait_for(0, 100, seen);
        chk("bub_done_seen", seen, 1);
        repeat (3) @(negedge clk);
        chk("bub_req_cycles", req_cycles, 4);
        chk("bub_words", m_words, 4);
        chk("bub_sb_empty", exp_q.size(), 0);

        // ---- watchdog in REQ (limit 5): second grant never comes
        sel = 1'b1;
        do_reset();
        block_gnt = 1;
        pulse_start();
        run_bulk(16'h00B0, 0, 2);
        wait_for(1, 30, seen);
        chk("wdq_idle_seen", seen, 1);
        chk("wdq_req_cycles", req_cycles, 6);
        chk("wdq_tmo", m_tmo, 1);
        chk("wdq_busy", m_busy, 0);
        chk("wdq_req_low", m_req, 0);
        chk("wdq_words", m_words, 1);
        chk("wdq_unwritten", exp_q.size(), 1);
        repeat (3) @(negedge clk);
        chk("wdq_done_cnt", done_cnt, 0);
        exp_q.delete();
        block_gnt = -1;
        pulse_start();
        chk("wdq_restart_tmo", m_tmo, 0);
        chk("wdq_restart_busy", m_busy, 1);
        chk("wdq_restart_words", m_words, 0);

        // ---- watchdog in RESP: rvalid on the limit cycle wins, one later loses
        do_reset();
        rv_delay = 4;
        pulse_start();
        feed(16'h00C0, 0, ok);
        chk("wdr_feed0", ok, 1);
        wait_for(2, 30, seen);
        chk("wdr_load_seen", seen, 1);
        chk("wdr_race_words", m_words, 1);
        chk("wdr_race_tmo", m_tmo, 0);
        rv_delay = 5;
        feed(16'h00C1, 0, ok);
        chk("wdr_feed1", ok, 1);
        wait_for(1, 30, seen);
        chk("wdr_idle_seen", seen, 1);
        chk("wdr_late_tmo", m_tmo, 1);
        repeat (3) @(negedge clk);
        chk("wdr_late_words", m_words, 1);
        chk("wdr_writes", wr_cnt, 2);
        chk("wdr_done_cnt", done_cnt, 0);

        // ---- start while busy, then reset mid-REQ and a stray rvalid
        sel = 1'b0;
        do_reset();
        pulse_start();
        feed(16'h00D0, 0, ok);
        chk("rs_feed0", ok, 1);
        rv_delay = 3;
        feed(16'h00D1, 0, ok);
        chk("rs_feed1", ok, 1);
        @(negedge clk);
        pulse_start();
        chk("rs_resp_s_ready", m_s_ready, 0);
        chk("rs_resp_busy", m_busy, 1);
        wait_for(2, 30, seen);
        chk("rs_load_seen", seen, 1);
        chk("rs_words_kept", m_words, 2);
        rv_delay = 0;
        gnt_wait = 3;
        feed(16'h00D2, 0, ok);
        chk("rs_feed2", ok, 1);
        chk("rs_req_latency", m_req, 1);
        rst_n = 1'b0;
        @(negedge clk);
        chk("rs_req", m_req, 0);
        chk("rs_words", m_words, 0);
        chk("rs_busy", m_busy, 0);
        chk("rs_wdata", m_wdata, 0);
        chk("rs_s_ready", m_s_ready, 0);
        rst_n = 1'b1;
        stray_rv = 1'b1;
        repeat (3) @(negedge clk);
        chk("rs_stray_words", m_words, 0);
        chk("rs_stray_busy", m_busy, 0);
        chk("rs_unwritten", exp_q.size(), 1);
        exp_q.delete();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
